tpu_skew_feeder: RTL and testbench
==================================

Name: tpu_skew_feeder

Overview:
- Upstream stage of the systolic MAC array.
- Buffers a DIM x DIM tile of signed BITS_AB operands, written one row-vector per cycle.
- Streams the tile into the array's left edge with diagonal skew: lane r delayed r cycles.
- Drives the array's shared enable.

Parameters:
BITS_AB, 8, operand width (matches the MAC A/B width)
DIM, 8, array dimension: lanes, tile rows and tile columns (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset
clr  input  1  synchronous clear of the load and stream state
wr_en  input  1  write one row-vector into the tile buffer
wr_data  input  DIM*BITS_AB  row-vector; element c at bits [c*BITS_AB +: BITS_AB]
wr_ready  output  1  buffer accepting writes
loaded  output  1  DIM rows written, tile complete
start  input  1  begin streaming a loaded tile
stall  input  1  freeze streaming this cycle
busy  output  1  streaming in progress
en_out  output  1  enable to the array; high on each advancing stream cycle
a_out  output  DIM*BITS_AB  lane r at bits [r*BITS_AB +: BITS_AB], feeds array row r Ain
done  output  1  one-cycle pulse after the last stream cycle

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- On reset: wr_ready=1, loaded=0, busy=0, en_out=0, done=0, a_out=0, wr_ptr=0, state IDLE. Buffer contents are not reset.
- States:
  - IDLE: loading allowed.
  - STREAM: counter k runs 0..2*DIM-2.
  - DONE: single cycle, then back to IDLE.
- Load (IDLE, !loaded):
  - wr_en stores wr_data as buffer row wr_ptr, then wr_ptr increments.
  - On the DIM-th write: loaded=1 and wr_ready=0 next cycle.
  - wr_en while wr_ready=0 is ignored; buffer and wr_ptr unchanged.
- Start:
  - Accepted only in IDLE with loaded=1. Otherwise ignored, with no side effects.
  - Next cycle: state STREAM, k=0, busy=1.
- Stream output (registered):
  - In STREAM with stall=0, en_out=1 and lane r = buffer[r][k-r] when 0 <= k-r <= DIM-1, else 0.
  - k increments after each such cycle.
  - Total window is 2*DIM-1 advancing cycles.
  - Element (r,c) appears on lane r exactly at advancing cycle r+c.
- Stall:
  - In STREAM with stall=1: en_out=0, a_out holds its previous value, k holds.
  - Stall outside STREAM has no effect.
- Completion:
  - After advancing cycle k=2*DIM-2, the state goes to DONE.
  - In DONE: done=1, en_out=0, a_out=0, busy=0.
  - Also in DONE: loaded cleared, wr_ptr cleared, wr_ready=1. The next cycle is IDLE.
- Writes during STREAM or DONE are ignored.
- clr (any state, highest priority after reset):
  - Next cycle: IDLE, wr_ptr=0, loaded=0, wr_ready=1, busy=0, en_out=0, a_out=0.
  - No done pulse; an in-flight stream is aborted.
- Simultaneous events in the same cycle:
  - clr beats start, wr_en and stall.
  - start with wr_en is impossible to accept both: start requires loaded, so wr_en is ignored.
  - The final (DIM-th) write with start in the same cycle: start is ignored because loaded is not yet 1.
- Values are passed through bit-exact; no arithmetic or sign extension.

Optional Feature:
- Macro: TPU_SKEW_FEEDER_TRANSPOSE_EN.
- Defined: each write stores wr_data element j into buffer[j][wr_ptr], i.e. writes fill columns. Lane r then streams written-vector elements r in write order, with the same skew. This loads B-style column tiles without host transposition.
- Undefined: writes fill rows as described above.
- All timing, handshakes and other behaviour are identical in both builds.

Test Plan:
- DIM=4, write rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, then start:
  - 7 en_out cycles.
  - Lane0 = 1,2,3,4,0,0,0.
  - Lane3 = 0,0,0,13,14,15,16.
  - done pulses once after the seventh cycle.
- Same tile, stall high during cycles 2 and 3 of the window: en_out low for those 2 cycles, a_out holds, lane sequences unchanged. done arrives 2 cycles later than without stall.
- Start after only 3 writes: ignored, busy stays 0. Then fifth attempted write after 4 writes: ignored, loaded=1, wr_ready=0.
- clr asserted at stream cycle 3: next cycle busy=0, a_out=0, loaded=0, no done. A new load and stream then produces the correct sequences.
- rst_n deasserted asynchronously mid-stream: outputs 0 immediately, wr_ready=1.
- With TPU_SKEW_FEEDER_TRANSPOSE_EN defined, same writes: lane0 = 1,5,9,13,0,0,0 and lane1 = 0,2,6,10,14,0,0.

Source files
------------

// File: rtl/tpu_skew_feeder_if.sv
// Host/array-side bundle of the tile skew feeder: load handshake, stream control and skewed output.
// The master modport is the host/controller side, the slave modport is the feeder itself.
interface tpu_skew_feeder_if #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned DIM     = 8
);
   logic                   clr;
   logic                   wr_en;
   logic [DIM*BITS_AB-1:0] wr_data;
   logic                   wr_ready;
   logic                   loaded;
   logic                   start;
   logic                   stall;
   logic                   busy;
   logic                   en_out;
   logic [DIM*BITS_AB-1:0] a_out;
   logic                   done;

   modport master (
      output clr, wr_en, wr_data, start, stall,
      input  wr_ready, loaded, busy, en_out, a_out, done
   );

   modport slave (
      input  clr, wr_en, wr_data, start, stall,
      output wr_ready, loaded, busy, en_out, a_out, done
   );
endinterface

// File: rtl/tpu_skew_feeder.sv
// Buffers a DIM x DIM operand tile and streams it diagonally skewed into the systolic array.
// Define TPU_SKEW_FEEDER_TRANSPOSE_EN to make each written vector fill a buffer column.
module tpu_skew_feeder #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned DIM     = 8
) (
   input logic             clk,
   input logic             rst_n,
   tpu_skew_feeder_if.slave bus
);
   localparam int unsigned PW = $clog2(DIM);
   localparam int unsigned KW = $clog2(2 * DIM);
   localparam int unsigned W  = DIM * BITS_AB;
   localparam logic [KW-1:0] KDrain = KW'(2 * DIM - 1);
   localparam logic [PW-1:0] PtrLast = PW'(DIM - 1);

   typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [KW-1:0]      k_q, k_d;
   logic               loaded_q, loaded_d;
   logic               busy_q, busy_d;
   logic               en_q, en_d;
   logic               done_q, done_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       lane;
   logic [BITS_AB-1:0] buf_q [DIM][DIM];
   logic               wr_fire;

   assign wr_fire = !bus.clr && (state_q == StIdle) && !loaded_q && bus.wr_en;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int j = 0; j < DIM; j++) begin
`ifdef TPU_SKEW_FEEDER_TRANSPOSE_EN
            buf_q[j][wr_ptr_q] <= bus.wr_data[j*BITS_AB +: BITS_AB];
`else
            buf_q[wr_ptr_q][j] <= bus.wr_data[j*BITS_AB +: BITS_AB];
`endif
         end
      end
   end

   // Lane r carries column k-r of its buffer row; zero outside the diagonal window.
   always_comb begin
      lane = '0;
      for (int r = 0; r < DIM; r++) begin
         if ((int'(k_q) >= r) && (int'(k_q) - r < int'(DIM))) begin
            lane[r*BITS_AB +: BITS_AB] = buf_q[r][PW'(int'(k_q) - r)];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      k_d      = k_q;
      loaded_d = loaded_q;
      busy_d   = busy_q;
      en_d     = en_q;
      a_d      = a_q;
      done_d   = 1'b0;

      if (bus.clr) begin
         state_d  = StIdle;
         wr_ptr_d = '0;
         k_d      = '0;
         loaded_d = 1'b0;
         busy_d   = 1'b0;
         en_d     = 1'b0;
         a_d      = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_fire) begin
                  if (wr_ptr_q == PtrLast) begin
                     wr_ptr_d = '0;
                     loaded_d = 1'b1;
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
               end
               if (bus.start && loaded_q) begin
                  state_d = StStream;
                  k_d     = '0;
                  busy_d  = 1'b1;
               end
            end
            StStream: begin
               // k == 2*DIM-1 is the cycle the last beat is visible; wrap up from there.
               if (k_q == KDrain) begin
                  state_d  = StDone;
                  k_d      = '0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  en_d     = 1'b0;
                  a_d      = '0;
                  loaded_d = 1'b0;
                  wr_ptr_d = '0;
               end else if (!bus.stall) begin
                  en_d = 1'b1;
                  a_d  = lane;
                  k_d  = k_q + 1'b1;
               end else begin
                  en_d = 1'b0;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         k_q      <= '0;
         loaded_q <= 1'b0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         a_q      <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         k_q      <= k_d;
         loaded_q <= loaded_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         done_q   <= done_d;
         a_q      <= a_d;
      end
   end

   assign bus.wr_ready = !loaded_q;
   assign bus.loaded   = loaded_q;
   assign bus.busy     = busy_q;
   assign bus.en_out   = en_q;
   assign bus.a_out    = a_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Self-checking bench for tpu_skew_feeder at DIM=4: vector table of tiles/stall patterns plus
// hand-written partial-load, clear and async-reset sequences; beats checked through a queue.
module tb_tpu_skew_feeder;
   localparam int unsigned BITS_AB = 8;
   localparam int unsigned DIM     = 4;
   localparam int unsigned W       = DIM * BITS_AB;
   localparam int unsigned TW      = DIM * DIM * BITS_AB;
   localparam int          NBEAT   = 2 * DIM - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tpu_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

   tpu_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [TW-1:0] tile;
      logic [15:0]   stall_mask;
      int            done_lat;
      logic [55:0]   lane0;
      logic [55:0]   lane3;
   } vec_t;

   vec_t          vecs[3];
   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [TW-1:0] base_tile, hi_tile;
   logic [55:0]   got0, got3;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [BITS_AB-1:0] elem(input logic [TW-1:0] t, input int r, input int c);
      return t[(r*DIM+c)*BITS_AB +: BITS_AB];
   endfunction

   // Expected a_out for advancing beat k, taken from the tile as the host wrote it.
   function automatic logic [W-1:0] model_out(input logic [TW-1:0] t, input int k);
      logic [W-1:0] v;
      v = '0;
      for (int r = 0; r < DIM; r++) begin
         int c;
         c = k - r;
         if (c >= 0 && c < int'(DIM)) begin
`ifdef TPU_SKEW_FEEDER_TRANSPOSE_EN
            v[r*BITS_AB +: BITS_AB] = elem(t, c, r);
`else
            v[r*BITS_AB +: BITS_AB] = elem(t, r, c);
`endif
         end
      end
      return v;
   endfunction

   // Called just after a negedge; returns just after the next negedge.
   task automatic write_row(input logic [W-1:0] d, input logic st);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      bus.start   = st;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic load_tile(input logic [TW-1:0] t, input int n);
      for (int r = 0; r < n; r++) begin
         check("wr_ready_load", bus.wr_ready, 1);
         write_row(t[r*W +: W], 1'b0);
      end
      if (n == int'(DIM)) begin
         check("loaded_full", bus.loaded, 1);
         check("wr_ready_full", bus.wr_ready, 0);
      end
   endtask

   task automatic run_stream(input vec_t v, output logic [55:0] l0, output logic [55:0] l3);
      int           cyc;
      int           n_en;
      logic [W-1:0] last;
      l0   = '0;
      l3   = '0;
      n_en = 0;
      last = '0;
      for (int k = 0; k < NBEAT; k++) exp_q.push_back(model_out(v.tile, k));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      while (cyc < 40 && !bus.done) begin
         check("busy_stream", bus.busy, 1);
         if (bus.en_out) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", bus.a_out, 0);
            end else begin
               check("a_out_beat", bus.a_out, exp_q.pop_front());
            end
            if (n_en < NBEAT) begin
               l0[n_en*8 +: 8] = bus.a_out[7:0];
               l3[n_en*8 +: 8] = bus.a_out[3*BITS_AB +: BITS_AB];
            end
            n_en++;
            last = bus.a_out;
         end else if (n_en > 0) begin
            check("a_out_hold", bus.a_out, last);
         end
         bus.stall = (cyc - 1 < 16) ? v.stall_mask[cyc-1] : 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.stall = 1'b0;
      check("done_latency", cyc, v.done_lat);
      check("beat_count", n_en, NBEAT);
      check("queue_empty", exp_q.size(), 0);
      check("done_en_out", bus.en_out, 0);
      check("done_a_out", bus.a_out, 0);
      check("done_busy", bus.busy, 0);
      check("done_loaded", bus.loaded, 0);
      check("done_wr_ready", bus.wr_ready, 1);
      exp_q.delete();
      @(negedge clk);
      check("done_single", bus.done, 0);
   endtask

   initial begin
      int seen;
      bus.clr     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      bus.stall   = 1'b0;

      for (int r = 0; r < int'(DIM); r++) begin
         for (int c = 0; c < int'(DIM); c++) begin
            base_tile[(r*DIM+c)*BITS_AB +: BITS_AB] = 8'(r * DIM + c + 1);
            hi_tile[(r*DIM+c)*BITS_AB +: BITS_AB]   = 8'(8'h80 + r * DIM + c);
         end
      end
      vecs[0].tile = base_tile; vecs[0].stall_mask = 16'h0000; vecs[0].done_lat = 9;
      vecs[1].tile = base_tile; vecs[1].stall_mask = 16'h000C; vecs[1].done_lat = 11;
      vecs[2].tile = hi_tile;   vecs[2].stall_mask = 16'h0041; vecs[2].done_lat = 11;
`ifdef TPU_SKEW_FEEDER_TRANSPOSE_EN
      vecs[0].lane0 = 56'h00_00_00_0D_09_05_01; vecs[0].lane3 = 56'h10_0C_08_04_00_00_00;
      vecs[2].lane0 = 56'h00_00_00_8C_88_84_80; vecs[2].lane3 = 56'h8F_8B_87_83_00_00_00;
`else
      vecs[0].lane0 = 56'h00_00_00_04_03_02_01; vecs[0].lane3 = 56'h10_0F_0E_0D_00_00_00;
      vecs[2].lane0 = 56'h00_00_00_83_82_81_80; vecs[2].lane3 = 56'h8F_8E_8D_8C_00_00_00;
`endif
      vecs[1].lane0 = vecs[0].lane0;
      vecs[1].lane3 = vecs[0].lane3;

      #3;
      check("rst_wr_ready", bus.wr_ready, 1);
      check("rst_loaded", bus.loaded, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_en_out", bus.en_out, 0);
      check("rst_done", bus.done, 0);
      check("rst_a_out", bus.a_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Partial load: start ignored, start with the final write ignored, fifth write ignored.
      load_tile(base_tile, 3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("partial_busy", bus.busy, 0);
      check("partial_loaded", bus.loaded, 0);
      write_row(base_tile[3*W +: W], 1'b1);
      check("last_wr_start_busy", bus.busy, 0);
      check("last_wr_loaded", bus.loaded, 1);
      check("last_wr_ready", bus.wr_ready, 0);
      write_row(32'hDEAD_BEEF, 1'b0);
      check("fifth_wr_loaded", bus.loaded, 1);
      check("fifth_wr_ready", bus.wr_ready, 0);
      check("fifth_wr_busy", bus.busy, 0);
      run_stream(vecs[0], got0, got3);
      check("partial_lane0", got0, vecs[0].lane0);
      check("partial_lane3", got3, vecs[0].lane3);

      for (int i = 0; i < 3; i++) begin
         load_tile(vecs[i].tile, DIM);
         run_stream(vecs[i], got0, got3);
         check("vec_lane0", got0, vecs[i].lane0);
         check("vec_lane3", got3, vecs[i].lane3);
      end

      // Clear in the middle of a stream.
      load_tile(base_tile, DIM);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         @(negedge clk);
         if (bus.en_out) seen++;
      end
      check("clr_reach_beat3", seen, 3);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      check("clr_busy", bus.busy, 0);
      check("clr_a_out", bus.a_out, 0);
      check("clr_en_out", bus.en_out, 0);
      check("clr_loaded", bus.loaded, 0);
      check("clr_wr_ready", bus.wr_ready, 1);
      for (int i = 0; i < 4; i++) begin
         check("clr_no_done", bus.done, 0);
         @(negedge clk);
      end
      load_tile(vecs[2].tile, DIM);
      run_stream(vecs[2], got0, got3);
      check("post_clr_lane0", got0, vecs[2].lane0);
      check("post_clr_lane3", got3, vecs[2].lane3);

      // Asynchronous reset in the middle of a stream.
      load_tile(base_tile, DIM);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && seen < 2; i++) begin
         @(negedge clk);
         if (bus.en_out) seen++;
      end
      check("arst_reach_beat2", seen, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_a_out", bus.a_out, 0);
      check("arst_en_out", bus.en_out, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_wr_ready", bus.wr_ready, 1);
      check("arst_loaded", bus.loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load_tile(vecs[1].tile, DIM);
      run_stream(vecs[1], got0, got3);
      check("post_arst_lane0", got0, vecs[1].lane0);
      check("post_arst_lane3", got3, vecs[1].lane3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
